// File: rtl/mem_arbiter.sv
// Two-requester arbiter: the I-cache and D-cache share one block-transfer memory port.
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate grants on ties (default: D-cache has fixed priority).
`ifndef CACHE_BLOCK_SIZE
  `define CACHE_BLOCK_SIZE 64
`endif
`ifndef MEM_TRANS_SIZE
  `define MEM_TRANS_SIZE 16
`endif

module mem_arbiter #(
  localparam int unsigned DATA_W    = `MEM_TRANS_SIZE,
  localparam int unsigned BEATS     = `CACHE_BLOCK_SIZE / `MEM_TRANS_SIZE,
  localparam int unsigned ADDR_BITS = 16 - $clog2(`CACHE_BLOCK_SIZE),
  localparam int unsigned CNT_BITS  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic [ADDR_BITS-1:0] i_address,
  output logic                 i_ack,
  output logic [DATA_W-1:0]    i_data,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ADDR_BITS-1:0] d_address,
  input  logic [DATA_W-1:0]    d_wdata,
  output logic                 d_ack,
  output logic [DATA_W-1:0]    d_rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_address,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic                 mem_ack,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 busy,
  output logic                 owner
);

  typedef enum logic [1:0] {IDLE, REQUEST, TRANSFER} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                grant;
  logic                owner_req;

  always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
    grant = (i_req && d_req) ? ~owner_q : d_req;
`else
    grant = d_req;
`endif
    owner_req = owner_q ? d_req : i_req;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          owner_d = grant;
          state_d = REQUEST;
        end
      end
      REQUEST: begin
        if (!owner_req) begin
          state_d = IDLE;
        end else if (mem_ack) begin
          // Direction is latched at ack so beats stay correct if the cache drops d_we.
          we_d    = owner_q & d_we;
          cnt_d   = '0;
          state_d = TRANSFER;
        end
      end
      TRANSFER: begin
        if (cnt_q == CNT_BITS'(BEATS - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
    end
  end

  // Memory-side handshake is combinational so an abort or ack takes effect in the same cycle.
  always_comb begin
    logic in_req;
    logic in_xfer;
    in_req      = (state_q == REQUEST);
    in_xfer     = (state_q == TRANSFER);
    mem_req     = in_req & owner_req;
    mem_we      = in_req & owner_q & d_we;
    mem_address = in_req ? (owner_q ? d_address : i_address) : '0;
    mem_wdata   = (in_xfer && owner_q && we_q) ? d_wdata : '0;
    i_ack       = in_req & ~owner_q & i_req & mem_ack;
    d_ack       = in_req & owner_q & d_req & mem_ack;
    i_data      = (in_xfer && !owner_q) ? mem_rdata : '0;
    d_rdata     = (in_xfer && owner_q && !we_q) ? mem_rdata : '0;
    busy        = (state_q != IDLE);
    owner       = owner_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with CACHE_BLOCK_SIZE=64, MEM_TRANS_SIZE=16 (4 beats, 10-bit block address).
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we, mem_ack;
  logic [9:0]  i_address, d_address, mem_address;
  logic [15:0] d_wdata, mem_rdata, i_data, d_rdata, mem_wdata;
  logic        i_ack, d_ack, mem_req, mem_we, busy, owner;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_address(i_address), .i_ack(i_ack), .i_data(i_data),
    .d_req(d_req), .d_we(d_we), .d_address(d_address), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  typedef struct {
    logic rst, i_req; logic [9:0] i_addr;
    logic d_req, d_we; logic [9:0] d_addr; logic [15:0] d_wdata;
    logic mem_ack; logic [15:0] mem_rdata; logic chk;
    logic i_ack; logic [15:0] i_data; logic d_ack; logic [15:0] d_rdata;
    logic mem_req, mem_we; logic [9:0] mem_addr; logic [15:0] mem_wdata;
    logic busy, owner;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, ir, input logic [9:0] ia, input logic dr, dw,
                     input logic [9:0] da, input logic [15:0] dwd, input logic ma,
                     input logic [15:0] mrd, input logic c,
                     input logic eia, input logic [15:0] eid, input logic eda,
                     input logic [15:0] edr, input logic emr, emw, input logic [9:0] ema,
                     input logic [15:0] emwd, input logic eb, eo);
    vec_t v;
    v.rst = r; v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_we = dw; v.d_addr = da;
    v.d_wdata = dwd; v.mem_ack = ma; v.mem_rdata = mrd; v.chk = c;
    v.i_ack = eia; v.i_data = eid; v.d_ack = eda; v.d_rdata = edr; v.mem_req = emr;
    v.mem_we = emw; v.mem_addr = ema; v.mem_wdata = emwd; v.busy = eb; v.owner = eo;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    rst = 1'b0; i_req = 1'b0; i_address = '0; d_req = 1'b0; d_we = 1'b0;
    d_address = '0; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    //  rst ir ia      dr dw da      dwd       ma mrd      c | iack idata    dack drd mreq mwe maddr   mwd       busy own
    add(0, 0, 10'h000, 0, 0, 10'h000, 16'h0000, 0, 16'h0000, 1,  0, 16'h0000, 0, 16'h0, 0, 0, 10'h000, 16'h0000, 0, 0);
    // I-cache read, memory acks on the third REQUEST cycle
    add(0, 1, 10'h155, 0, 0, 10'h000, 16'h0000, 0, 16'h0000, 1,  0, 16'h0000, 0, 16'h0, 0, 0, 10'h000, 16'h0000, 0, 0);
    add(0, 1, 10'h155, 0, 0, 10'h000, 16'h0000, 0, 16'h0000, 1,  0, 16'h0000, 0, 16'h0, 1, 0, 10'h155, 16'h0000, 1, 0);
    add(0, 1, 10'h155, 0, 0, 10'h000, 16'h0000, 0, 16'h0000, 1,  0, 16'h0000, 0, 16'h0, 1, 0, 10'h155, 16'h0000, 1, 0);
    add(0, 1, 10'h155, 0, 0, 10'h000, 16'h0000, 1, 16'h0000, 1,  1, 16'h0000, 0, 16'h0, 1, 0, 10'h155, 16'h0000, 1, 0);
    add(0, 0, 10'h000, 0, 0, 10'h000, 16'h0000, 0, 16'h1111, 1,  0, 16'h1111, 0, 16'h0, 0, 0, 10'h000, 16'h0000, 1, 0);
    add(0, 0, 10'h000, 0, 0, 10'h000, 16'h0000, 0, 16'h2222, 1,  0, 16'h2222, 0, 16'h0, 0, 0, 10'h000, 16'h0000, 1, 0);
    add(0, 0, 10'h000, 0, 0, 10'h000, 16'h0000, 0, 16'h3333, 1,  0, 16'h3333, 0, 16'h0, 0, 0, 10'h000, 16'h0000, 1, 0);
    add(0, 0, 10'h000, 0, 0, 10'h000, 16'h0000, 0, 16'h4444, 1,  0, 16'h4444, 0, 16'h0, 0, 0, 10'h000, 16'h0000, 1, 0);
    add(0, 0, 10'h000, 0, 0, 10'h000, 16'h0000, 0, 16'h5555, 1,  0, 16'h0000, 0, 16'h0, 0, 0, 10'h000, 16'h0000, 0, 0);
    // D-cache write-back; read data on the bus must not reach either cache
    add(0, 0, 10'h000, 1, 1, 10'h3FF, 16'h0000, 0, 16'h0000, 1,  0, 16'h0000, 0, 16'h0, 0, 0, 10'h000, 16'h0000, 0, 0);
    add(0, 0, 10'h000, 1, 1, 10'h3FF, 16'h0000, 0, 16'h0000, 1,  0, 16'h0000, 0, 16'h0, 1, 1, 10'h3FF, 16'h0000, 1, 1);
    add(0, 0, 10'h000, 1, 1, 10'h3FF, 16'h0000, 1, 16'h0000, 1,  0, 16'h0000, 1, 16'h0, 1, 1, 10'h3FF, 16'h0000, 1, 1);
    add(0, 0, 10'h000, 0, 0, 10'h000, 16'hA0A0, 0, 16'hFFFF, 1,  0, 16'h0000, 0, 16'h0, 0, 0, 10'h000, 16'hA0A0, 1, 1);
    add(0, 0, 10'h000, 0, 0, 10'h000, 16'hA1A1, 0, 16'hFFFF, 1,  0, 16'h0000, 0, 16'h0, 0, 0, 10'h000, 16'hA1A1, 1, 1);
    add(0, 0, 10'h000, 0, 0, 10'h000, 16'hA2A2, 0, 16'hFFFF, 1,  0, 16'h0000, 0, 16'h0, 0, 0, 10'h000, 16'hA2A2, 1, 1);
    add(0, 0, 10'h000, 0, 0, 10'h000, 16'hA3A3, 0, 16'hFFFF, 1,  0, 16'h0000, 0, 16'h0, 0, 0, 10'h000, 16'hA3A3, 1, 1);
    add(0, 0, 10'h000, 0, 0, 10'h000, 16'hA4A4, 0, 16'h0000, 1,  0, 16'h0000, 0, 16'h0, 0, 0, 10'h000, 16'h0000, 0, 1);
    // reset after beat 1 of an I-cache read, then a fresh read
    add(0, 1, 10'h0AA, 0, 0, 10'h000, 16'h0000, 0, 16'h0000, 1,  0, 16'h0000, 0, 16'h0, 0, 0, 10'h000, 16'h0000, 0, 1);
    add(0, 1, 10'h0AA, 0, 0, 10'h000, 16'h0000, 1, 16'h0000, 1,  1, 16'h0000, 0, 16'h0, 1, 0, 10'h0AA, 16'h0000, 1, 0);
    add(0, 0, 10'h000, 0, 0, 10'h000, 16'h0000, 0, 16'h1111, 1,  0, 16'h1111, 0, 16'h0, 0, 0, 10'h000, 16'h0000, 1, 0);
    add(0, 0, 10'h000, 0, 0, 10'h000, 16'h0000, 0, 16'h2222, 1,  0, 16'h2222, 0, 16'h0, 0, 0, 10'h000, 16'h0000, 1, 0);
    add(1, 0, 10'h000, 0, 0, 10'h000, 16'h0000, 0, 16'h3333, 0,  0, 16'h0000, 0, 16'h0, 0, 0, 10'h000, 16'h0000, 0, 0);
    add(0, 0, 10'h000, 0, 0, 10'h000, 16'h0000, 0, 16'h4444, 1,  0, 16'h0000, 0, 16'h0, 0, 0, 10'h000, 16'h0000, 0, 0);
    add(0, 1, 10'h123, 0, 0, 10'h000, 16'h0000, 0, 16'h0000, 1,  0, 16'h0000, 0, 16'h0, 0, 0, 10'h000, 16'h0000, 0, 0);
    add(0, 1, 10'h123, 0, 0, 10'h000, 16'h0000, 1, 16'h0000, 1,  1, 16'h0000, 0, 16'h0, 1, 0, 10'h123, 16'h0000, 1, 0);
    add(0, 0, 10'h000, 0, 0, 10'h000, 16'h0000, 0, 16'h0005, 1,  0, 16'h0005, 0, 16'h0, 0, 0, 10'h000, 16'h0000, 1, 0);
    add(0, 0, 10'h000, 0, 0, 10'h000, 16'h0000, 0, 16'h0006, 1,  0, 16'h0006, 0, 16'h0, 0, 0, 10'h000, 16'h0000, 1, 0);
    add(0, 0, 10'h000, 0, 0, 10'h000, 16'h0000, 0, 16'h0007, 1,  0, 16'h0007, 0, 16'h0, 0, 0, 10'h000, 16'h0000, 1, 0);
    add(0, 0, 10'h000, 0, 0, 10'h000, 16'h0000, 0, 16'h0008, 1,  0, 16'h0008, 0, 16'h0, 0, 0, 10'h000, 16'h0000, 1, 0);
    add(0, 0, 10'h000, 0, 0, 10'h000, 16'h0000, 0, 16'h0009, 1,  0, 16'h0000, 0, 16'h0, 0, 0, 10'h000, 16'h0000, 0, 0);
    // D-cache read aborted in REQUEST, late mem_ack must be ignored
    add(0, 0, 10'h000, 1, 0, 10'h2AA, 16'h0000, 0, 16'h0000, 1,  0, 16'h0000, 0, 16'h0, 0, 0, 10'h000, 16'h0000, 0, 0);
    add(0, 0, 10'h000, 1, 0, 10'h2AA, 16'h0000, 0, 16'h0000, 1,  0, 16'h0000, 0, 16'h0, 1, 0, 10'h2AA, 16'h0000, 1, 1);
    add(0, 0, 10'h000, 0, 0, 10'h000, 16'h0000, 0, 16'h0000, 1,  0, 16'h0000, 0, 16'h0, 0, 0, 10'h000, 16'h0000, 1, 1);
    add(0, 0, 10'h000, 0, 0, 10'h000, 16'h0000, 1, 16'hBEEF, 1,  0, 16'h0000, 0, 16'h0, 0, 0, 10'h000, 16'h0000, 0, 1);

    for (int unsigned n = 0; n < vecs.size(); n++) begin
      vec_t v;
      v = vecs[n];
      @(posedge clk);
      #1;
      rst = v.rst; i_req = v.i_req; i_address = v.i_addr; d_req = v.d_req; d_we = v.d_we;
      d_address = v.d_addr; d_wdata = v.d_wdata; mem_ack = v.mem_ack; mem_rdata = v.mem_rdata;
      @(negedge clk);
      if (v.chk) begin
        check($sformatf("v%0d i_ack", n),       32'(i_ack),       32'(v.i_ack));
        check($sformatf("v%0d i_data", n),      32'(i_data),      32'(v.i_data));
        check($sformatf("v%0d d_ack", n),       32'(d_ack),       32'(v.d_ack));
        check($sformatf("v%0d d_rdata", n),     32'(d_rdata),     32'(v.d_rdata));
        check($sformatf("v%0d mem_req", n),     32'(mem_req),     32'(v.mem_req));
        check($sformatf("v%0d mem_we", n),      32'(mem_we),      32'(v.mem_we));
        check($sformatf("v%0d mem_address", n), 32'(mem_address), 32'(v.mem_addr));
        check($sformatf("v%0d mem_wdata", n),   32'(mem_wdata),   32'(v.mem_wdata));
        check($sformatf("v%0d busy", n),        32'(busy),        32'(v.busy));
        check($sformatf("v%0d owner", n),       32'(owner),       32'(v.owner));
      end
    end

    // Repeated ties straight out of reset: grant order and one IDLE bubble between grants.
    @(posedge clk);
    #1 drive_idle(); rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int g = 0; g < 4; g++) begin
      logic exp_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_d = (g % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
      i_address = 10'h011; d_address = 10'h022; mem_ack = 1'b0;
      @(negedge clk);
      check($sformatf("tie%0d idle busy", g),    32'(busy),    32'd0);
      check($sformatf("tie%0d idle mem_req", g), 32'(mem_req), 32'd0);
      @(posedge clk);
      #1 mem_ack = 1'b1;
      @(negedge clk);
      check($sformatf("tie%0d owner", g),   32'(owner),       32'(exp_d));
      check($sformatf("tie%0d d_ack", g),   32'(d_ack),       32'(exp_d));
      check($sformatf("tie%0d i_ack", g),   32'(i_ack),       32'(!exp_d));
      check($sformatf("tie%0d address", g), 32'(mem_address), exp_d ? 32'h022 : 32'h011);
      for (int b = 0; b < 4; b++) begin
        @(posedge clk);
        #1 mem_ack = 1'b0; mem_rdata = 16'(16'hC000 + b);
        @(negedge clk);
        check($sformatf("tie%0d beat%0d d_rdata", g, b), 32'(d_rdata),
              exp_d ? 32'(16'hC000 + b) : 32'd0);
        check($sformatf("tie%0d beat%0d i_data", g, b), 32'(i_data),
              exp_d ? 32'd0 : 32'(16'hC000 + b));
      end
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
